// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multi-cycle RV32I core
// Sequences fetch/decode/execute/memory/writeback over the shared ALU and memory port.
module multicycle_control #(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       funct7_en,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       halted
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_ALU, MEM_ADDR, MEM_READ, MEM_WB,
    MEM_WRITE, ALU_WB, BRANCH, JAL, HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Only FETCH is a legal reset state; other values elaborate nothing extra.
  if (RESET_STATE_FETCH != 1) begin : g_unsupported_reset_state
  end

  state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_LUI:  state_d = EXEC_ALU;
          OP_LOAD, OP_STORE:   state_d = MEM_ADDR;
          OP_BRANCH:           state_d = BRANCH;
          OP_JAL:              state_d = JAL;
          default:             state_d = HALT;
        endcase
      end
      EXEC_ALU:  state_d = ALU_WB;
      ALU_WB:    state_d = FETCH;
      MEM_ADDR:  state_d = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ready) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (mem_ready) state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JAL:       state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    funct7_en = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      EXEC_ALU: begin
        if (opcode == OP_LUI) begin
          alu_src_b = 2'b01;
          alu_op    = 2'b11;
        end else if (opcode == OP_R) begin
          alu_src_a = 2'b01;
          alu_op    = 2'b10;
          funct7_en = 1'b1;
        end else begin
          // funct7[5] only selects SRA vs SRL among the immediate ops.
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
          funct7_en = (funct3 == 3'b101);
        end
      end
      MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
        retire    = 1'b1;
      end
      MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        retire  = mem_ready;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = alu_zero ^ funct3[0];
        retire    = 1'b1;
      end
      JAL: begin
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        retire    = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
    if (rst) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_we    = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule
